// File: rtl/uart_pkg.sv
// Shared UART definitions used by both the receiver and the transmitter:
// frame geometry, line idle level, FSM state encodings and a parity helper.
package uart_pkg;

    localparam int   UART_DATA_BITS          = 8;
    localparam int   UART_OVERSAMPLE_DEFAULT = 16;
    localparam logic UART_LINE_IDLE          = 1'b1;

    // State encodings kept as plain constants so older code can compare
    // against them directly.
    typedef logic [2:0] uart_state_t;

    localparam uart_state_t ST_IDLE   = 3'd0;
    localparam uart_state_t ST_START  = 3'd1;
    localparam uart_state_t ST_DATA   = 3'd2;
    localparam uart_state_t ST_PARITY = 3'd3;
    localparam uart_state_t ST_STOP   = 3'd4;
    localparam uart_state_t ST_BREAK  = 3'd5;

    // Parity bit a transmitter would send for this byte (odd = 1 inverts).
    function automatic logic uart_parity(input logic [UART_DATA_BITS-1:0] data,
                                         input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line. Both flops reset
// to the line idle level so that a reset never looks like a start bit.
module uart_rx_sync
    import uart_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic d_in,
    output logic d_sync
);

    logic meta_q;
    logic sync_q;

    // Two-stage resynchronisation of the raw line into the clk domain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= UART_LINE_IDLE;
            sync_q <= UART_LINE_IDLE;
        end else begin
            meta_q <= d_in;
            sync_q <= meta_q;
        end
    end

    assign d_sync = sync_q;

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver driven by an oversampling strobe. Each correctly framed
// byte is presented on data_out with a one-cycle data_valid pulse; a low stop
// bit gives a frame_error pulse and the FSM then waits out the break.
// Optional parity checking is compiled in with `define UART_RX_PARITY_EN.
module uart_receiver
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = UART_OVERSAMPLE_DEFAULT,
    parameter int PARITY_ODD = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_in,
    input  logic       sample_tick,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       frame_error,
    output logic       parity_error,
    output logic       busy
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam logic [TW-1:0] TICK_HALF = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [2:0]    BIT_LAST  = 3'(UART_DATA_BITS - 1);

    logic rx_s;

    uart_rx_sync u_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .d_in   (rx_in),
        .d_sync (rx_s)
    );

    uart_state_t               state_q,     state_d;
    logic [TW-1:0]             tick_cnt_q,  tick_cnt_d;
    logic [2:0]                bit_cnt_q,   bit_cnt_d;
    logic [UART_DATA_BITS-1:0] shift_q,     shift_d;
    logic [UART_DATA_BITS-1:0] data_out_q,  data_out_d;
    logic                      valid_q,     valid_d;
    logic                      ferr_q,      ferr_d;
    logic                      mid_start;
    logic                      mid_bit;
`ifdef UART_RX_PARITY_EN
    logic                      par_flag_q,  par_flag_d;
    logic                      perr_q,      perr_d;
`endif

    assign mid_start = sample_tick && (tick_cnt_q == TICK_HALF);
    assign mid_bit   = sample_tick && (tick_cnt_q == TICK_LAST);

    // Next-state, counter and datapath logic for the receive FSM.
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        data_out_d = data_out_q;
        valid_d    = 1'b0;
        ferr_d     = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_flag_d = par_flag_q;
        perr_d     = 1'b0;
`endif
        // Explicit wrap keeps non-power-of-two OVERSAMPLE values correct.
        tick_cnt_d = tick_cnt_q;
        if (sample_tick) begin
            tick_cnt_d = (tick_cnt_q == TICK_LAST) ? '0 : tick_cnt_q + TW'(1);
        end

        case (state_q)
            ST_IDLE: begin
                tick_cnt_d = '0;
                bit_cnt_d  = '0;
`ifdef UART_RX_PARITY_EN
                par_flag_d = 1'b0;
`endif
                if (!rx_s) begin
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (mid_start) begin
                    state_d = rx_s ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (mid_bit) begin
                    shift_d   = {rx_s, shift_q[UART_DATA_BITS-1:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (mid_bit) begin
                    if (rx_s != uart_parity(shift_q, PARITY_ODD != 0)) begin
                        par_flag_d = 1'b1;
                    end
                    state_d = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                if (mid_bit) begin
                    if (rx_s) begin
                        state_d = ST_IDLE;
`ifdef UART_RX_PARITY_EN
                        if (par_flag_q) begin
                            perr_d = 1'b1;
                        end else begin
                            data_out_d = shift_q;
                            valid_d    = 1'b1;
                        end
`else
                        data_out_d = shift_q;
                        valid_d    = 1'b1;
`endif
                    end else begin
                        // A low stop bit outranks any parity complaint.
                        ferr_d  = 1'b1;
                        state_d = ST_BREAK;
                    end
                end
            end
            ST_BREAK: begin
                tick_cnt_d = '0;
                if (rx_s) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Every state starts its own bit timing from zero.
        if (state_d != state_q) begin
            tick_cnt_d = '0;
        end
    end

    // State and datapath registers; reset aborts any frame in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            tick_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            data_out_q <= '0;
            valid_q    <= 1'b0;
            ferr_q     <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_flag_q <= 1'b0;
            perr_q     <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            tick_cnt_q <= tick_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            data_out_q <= data_out_d;
            valid_q    <= valid_d;
            ferr_q     <= ferr_d;
`ifdef UART_RX_PARITY_EN
            par_flag_q <= par_flag_d;
            perr_q     <= perr_d;
`endif
        end
    end

    assign data_out    = data_out_q;
    assign data_valid  = valid_q;
    assign frame_error = ferr_q;
    assign busy        = (state_q != ST_IDLE);

`ifdef UART_RX_PARITY_EN
    assign parity_error = perr_q;
`else
    // Parity sense has no effect in this build.
    logic unused_parity_cfg;
    assign unused_parity_cfg = (PARITY_ODD != 0);
    assign parity_error      = 1'b0;
`endif

endmodule
